// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall/flush controller:
//   - register-index and memory-response-code widths
//   - memory response codes (OK / WAIT / ERR)
//   - controller state encodings (HOLD / RUN / MEM_WAIT / FAULT)
//   - helper that classifies a raw response code
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int REG_IDX_W  = 5;
    localparam int MEM_CODE_W = 2;
    localparam int PC_STATE_W = 2;

    // Memory response codes. Encoding 2'd3 is unused and is treated as WAIT.
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_OK   = 2'd0;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_WAIT = 2'd1;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_ERR  = 2'd2;

    typedef enum logic [PC_STATE_W-1:0] {
        PC_HOLD     = 2'd0,
        PC_RUN      = 2'd1,
        PC_MEM_WAIT = 2'd2,
        PC_FAULT    = 2'd3
    } pc_state_e;

    typedef enum logic [1:0] {
        MEM_CLS_OK,
        MEM_CLS_WAIT,
        MEM_CLS_ERR
    } mem_cls_e;

    // Any code that is neither OK nor ERR behaves as WAIT, so a garbled
    // response stalls (and eventually times out) rather than releasing.
    function automatic mem_cls_e mem_classify(input logic [MEM_CODE_W-1:0] code);
        mem_cls_e cls;
        case (code)
            MEM_CODE_OK:  cls = MEM_CLS_OK;
            MEM_CODE_ERR: cls = MEM_CLS_ERR;
            default:      cls = MEM_CLS_WAIT;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
// Bundle between the pipeline stages and the stall/flush controller.
//   Hazard inputs : i_id_rs1, i_id_rs2, i_id_rs_used, i_ex_dest_reg,
//                   i_ex_is_load, i_branch, i_mem_req, i_mem_res_code
//   Control out   : o_stall[N_STAGES], o_clr[N_STAGES], o_fault, o_state
// Modports:
//   master - pipeline side: drives hazard info, receives stall/clr
//   slave  - controller side: receives hazard info, drives stall/clr
// -----------------------------------------------------------------------------
interface pipe_ctrl_if #(
    parameter int N_STAGES = 5
);
    import pipe_ctrl_pkg::*;

    logic [REG_IDX_W-1:0]  i_id_rs1;
    logic [REG_IDX_W-1:0]  i_id_rs2;
    logic [1:0]            i_id_rs_used;
    logic [REG_IDX_W-1:0]  i_ex_dest_reg;
    logic                  i_ex_is_load;
    logic                  i_branch;
    logic                  i_mem_req;
    logic [MEM_CODE_W-1:0] i_mem_res_code;
    logic [N_STAGES-1:0]   o_stall;
    logic [N_STAGES-1:0]   o_clr;
    logic                  o_fault;
    logic [PC_STATE_W-1:0] o_state;

    modport master (
        output i_id_rs1, i_id_rs2, i_id_rs_used, i_ex_dest_reg,
               i_ex_is_load, i_branch, i_mem_req, i_mem_res_code,
        input  o_stall, o_clr, o_fault, o_state
    );

    modport slave (
        input  i_id_rs1, i_id_rs2, i_id_rs_used, i_ex_dest_reg,
               i_ex_is_load, i_branch, i_mem_req, i_mem_res_code,
        output o_stall, o_clr, o_fault, o_state
    );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use compare. Flags a hazard when the instruction in EX
// is a load writing a non-zero register that the ID instruction reads.
// Ports:
//   i_id_rs1, i_id_rs2 : source registers of the ID instruction
//   i_id_rs_used       : bit0 = rs1 read, bit1 = rs2 read
//   i_ex_dest_reg      : destination register of the EX instruction
//   i_ex_is_load       : EX instruction is a load
//   o_hazard           : load-use interlock required this cycle
// -----------------------------------------------------------------------------
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] i_id_rs1,
    input  logic [REG_IDX_W-1:0] i_id_rs2,
    input  logic [1:0]           i_id_rs_used,
    input  logic [REG_IDX_W-1:0] i_ex_dest_reg,
    input  logic                 i_ex_is_load,
    output logic                 o_hazard
);

    logic dest_live;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign dest_live = i_ex_is_load && (i_ex_dest_reg != '0);
    assign rs1_hit   = i_id_rs_used[0] && (i_id_rs1 == i_ex_dest_reg);
    assign rs2_hit   = i_id_rs_used[1] && (i_id_rs2 == i_ex_dest_reg);
    assign o_hazard  = dest_live && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Central stall/flush controller for an N-stage in-order pipeline.
// Handles reset hold-off, load-use interlock, taken-branch flush and
// memory-wait stalls, with a watchdog on memory waits that parks the
// controller in a sticky FAULT state.
// Outputs are Mealy: they depend on the registered state and the current
// inputs, and take effect at the next clk edge.
// Ports:
//   clk      : clock
//   aresetn  : asynchronous active-low reset
//   i_resetn : synchronous active-low soft reset
//   bus      : pipe_ctrl_if.slave (hazard inputs, stall/clr/fault/state outputs)
// -----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int N_STAGES    = 5,
    parameter int EX_IDX      = 2,
    parameter int ME_IDX      = 3,   // EX_IDX < ME_IDX < N_STAGES-1
    parameter int RST_HOLD    = 2,   // >= 1
    parameter int MEM_TIMEOUT = 16   // >= 1
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        i_resetn,
    pipe_ctrl_if.slave  bus
);

    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam int TMR_W  = $clog2(MEM_TIMEOUT + 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(RST_HOLD - 1);
    localparam logic [TMR_W-1:0]  TMR_RELOAD  = TMR_W'(MEM_TIMEOUT - 1);

    pc_state_e           state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [TMR_W-1:0]    timer_q, timer_d;

    logic [N_STAGES-1:0] stall;
    logic [N_STAGES-1:0] clr;
    logic                load_use;
    mem_cls_e            mem_cls;

    // Per-action stage masks.
    logic [N_STAGES-1:0] wait_stall_mask;  // freeze FE..ME while memory is busy
    logic [N_STAGES-1:0] wait_clr_mask;    // bubble into the stage after ME
    logic [N_STAGES-1:0] br_clr_mask;      // flush stages between FE and EX
    logic [N_STAGES-1:0] lu_stall_mask;    // freeze FE..ID for one cycle
    logic [N_STAGES-1:0] lu_clr_mask;      // bubble into EX

    for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_mask
        assign wait_stall_mask[gi] = (gi <= ME_IDX);
        assign wait_clr_mask[gi]   = (gi == ME_IDX + 1);
        // FE redirects itself on a taken branch, so stage 0 is left alone.
        assign br_clr_mask[gi]     = (gi >= 1) && (gi < EX_IDX);
        assign lu_stall_mask[gi]   = (gi < EX_IDX);
        assign lu_clr_mask[gi]     = (gi == EX_IDX);
    end

    hazard_detect u_hazard_detect (
        .i_id_rs1      (bus.i_id_rs1),
        .i_id_rs2      (bus.i_id_rs2),
        .i_id_rs_used  (bus.i_id_rs_used),
        .i_ex_dest_reg (bus.i_ex_dest_reg),
        .i_ex_is_load  (bus.i_ex_is_load),
        .o_hazard      (load_use)
    );

    assign mem_cls = mem_classify(bus.i_mem_res_code);

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        timer_d    = timer_q;
        stall      = '0;
        clr        = '0;

        if (!i_resetn) begin
            state_d    = PC_HOLD;
            hold_cnt_d = HOLD_RELOAD;
            timer_d    = '0;
            clr        = '1;
        end else begin
            case (state_q)
                PC_HOLD: begin
                    // Hazard inputs are meaningless while the pipe is being flushed.
                    clr = '1;
                    if (hold_cnt_q == '0) begin
                        state_d = PC_RUN;
                    end else begin
                        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                    end
                end

                PC_RUN: begin
                    if (bus.i_mem_req && (mem_cls == MEM_CLS_ERR)) begin
                        // Freeze everything on the way into FAULT.
                        state_d = PC_FAULT;
                        stall   = '1;
                    end else if (bus.i_mem_req && (mem_cls == MEM_CLS_WAIT)) begin
                        stall   = wait_stall_mask;
                        clr     = wait_clr_mask;
                        state_d = PC_MEM_WAIT;
                        timer_d = TMR_RELOAD;
                    end else if (bus.i_branch) begin
                        // Also covers a simultaneous load-use: the dependent
                        // instruction is flushed, so no stall is needed.
                        clr = br_clr_mask;
                    end else if (load_use) begin
                        stall = lu_stall_mask;
                        clr   = lu_clr_mask;
                    end
                end

                PC_MEM_WAIT: begin
                    // EX is frozen here; branch/load-use re-present after release.
                    if (!bus.i_mem_req || (mem_cls == MEM_CLS_OK)) begin
                        state_d = PC_RUN;
                        timer_d = '0;
                    end else if ((mem_cls == MEM_CLS_ERR) || (timer_q == '0)) begin
                        state_d = PC_FAULT;
                        stall   = '1;
                    end else begin
                        stall   = wait_stall_mask;
                        clr     = wait_clr_mask;
                        timer_d = timer_q - TMR_W'(1);
                    end
                end

                PC_FAULT: begin
                    stall = '1;
                end

                default: begin
                    state_d = PC_HOLD;
                    clr     = '1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= PC_HOLD;
            hold_cnt_q <= HOLD_RELOAD;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            timer_q    <= timer_d;
        end
    end

    assign bus.o_stall = stall;
    assign bus.o_clr   = clr;
    assign bus.o_fault = (state_q == PC_FAULT);
    assign bus.o_state = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Scoreboard bench for pipe_ctrl. A stimulus process drives inputs just after
// each rising edge, runs a cycle-level reference model and pushes the expected
// outputs; a monitor pops and compares on each falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int N  = 5;
    localparam int EX = 2;
    localparam int ME = 3;
    localparam int RH = 2;
    localparam int MT = 16;

    logic clk = 1'b0;
    logic aresetn;
    logic i_resetn;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.N_STAGES(N)) bus();

    pipe_ctrl #(
        .N_STAGES    (N),
        .EX_IDX      (EX),
        .ME_IDX      (ME),
        .RST_HOLD    (RH),
        .MEM_TIMEOUT (MT)
    ) dut (
        .clk      (clk),
        .aresetn  (aresetn),
        .i_resetn (i_resetn),
        .bus      (bus)
    );

    typedef struct {
        int           tid;
        bit           chk_out;
        logic [1:0]   st;
        logic         flt;
        logic [N-1:0] stall;
        logic [N-1:0] clr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cur_tid  = 0;

    // Reference model state: spec-level quantities only.
    pc_state_e m_st;
    int        m_hold_left;   // clr cycles still owed after a reset
    int        m_wait_cnt;    // consecutive WAIT responses seen so far

    // Evaluate one cycle from the current inputs and advance the model.
    task automatic model_step();
        exp_t e;
        bit   lu;
        int   cls;  // 0 ok, 1 wait, 2 err
        e.tid     = cur_tid;
        e.chk_out = 1'b1;
        e.stall   = '0;
        e.clr     = '0;
        e.st      = m_st;
        e.flt     = (m_st == PC_FAULT);
        lu = bus.i_ex_is_load && (bus.i_ex_dest_reg != 0) &&
             ((bus.i_id_rs_used[0] && bus.i_id_rs1 == bus.i_ex_dest_reg) ||
              (bus.i_id_rs_used[1] && bus.i_id_rs2 == bus.i_ex_dest_reg));
        cls = (bus.i_mem_res_code == MEM_CODE_OK)  ? 0 :
              (bus.i_mem_res_code == MEM_CODE_ERR) ? 2 : 1;
        if (!aresetn) begin
            e.st = PC_HOLD; e.flt = 1'b0; e.clr = '1;
            m_st = PC_HOLD; m_hold_left = RH; m_wait_cnt = 0;
        end else if (!i_resetn) begin
            e.clr = '1;
            m_st = PC_HOLD; m_hold_left = RH; m_wait_cnt = 0;
        end else begin
            case (m_st)
                PC_HOLD: begin
                    e.clr = '1;
                    m_hold_left--;
                    if (m_hold_left == 0) m_st = PC_RUN;
                end
                PC_RUN: begin
                    if (bus.i_mem_req && cls == 2) begin
                        e.chk_out = 1'b0;
                        m_st = PC_FAULT;
                    end else if (bus.i_mem_req && cls == 1) begin
                        for (int i = 0; i <= ME; i++) e.stall[i] = 1'b1;
                        e.clr[ME+1] = 1'b1;
                        m_wait_cnt = 1;
                        m_st = PC_MEM_WAIT;
                    end else if (bus.i_branch) begin
                        for (int i = 1; i < EX; i++) e.clr[i] = 1'b1;
                    end else if (lu) begin
                        for (int i = 0; i < EX; i++) e.stall[i] = 1'b1;
                        e.clr[EX] = 1'b1;
                    end
                end
                PC_MEM_WAIT: begin
                    if (cls == 0) begin
                        m_st = PC_RUN;
                    end else if (cls == 2) begin
                        e.chk_out = 1'b0;
                        m_st = PC_FAULT;
                    end else begin
                        m_wait_cnt++;
                        if (m_wait_cnt > MT) begin
                            e.chk_out = 1'b0;
                            m_st = PC_FAULT;
                        end else begin
                            for (int i = 0; i <= ME; i++) e.stall[i] = 1'b1;
                            e.clr[ME+1] = 1'b1;
                        end
                    end
                end
                default: begin  // FAULT
                    e.stall = '1;
                end
            endcase
        end
        sb.push_back(e);
    endtask

    task automatic issue();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_id_rs1       = '0;
        bus.i_id_rs2       = '0;
        bus.i_id_rs_used   = '0;
        bus.i_ex_dest_reg  = '0;
        bus.i_ex_is_load   = 1'b0;
        bus.i_branch       = 1'b0;
        bus.i_mem_req      = 1'b0;
        bus.i_mem_res_code = MEM_CODE_OK;
    endtask

    // Monitor: compares DUT outputs against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (bus.o_state === e.st && bus.o_fault === e.flt &&
                    (!e.chk_out || (bus.o_stall === e.stall && bus.o_clr === e.clr))) begin
                    n_pass++;
                    $display("[%0t] tid=%0d state=%0d fault=%b stall=%b clr=%b ok",
                             $time, e.tid, bus.o_state, bus.o_fault, bus.o_stall, bus.o_clr);
                end else begin
                    $display("FAIL tid=%0d outputs: got state=%0d fault=%b stall=%b clr=%b, want state=%0d fault=%b stall=%b clr=%b%s",
                             e.tid, bus.o_state, bus.o_fault, bus.o_stall, bus.o_clr,
                             e.st, e.flt, e.stall, e.clr, e.chk_out ? "" : " (stall/clr unchecked)");
                end
            end
        end
    end

    initial begin
        int r;
        aresetn  = 1'b0;
        i_resetn = 1'b1;
        idle_inputs();
        m_st = PC_HOLD; m_hold_left = RH; m_wait_cnt = 0;
        @(posedge clk);
        #1;

        // 1: async reset for 3 cycles, then hold-off, then RUN
        cur_tid = 1;
        repeat (3) issue();
        aresetn = 1'b1;
        repeat (3) issue();

        // 2: load-use, then same with x0 destination
        cur_tid = 2;
        bus.i_ex_is_load = 1'b1; bus.i_ex_dest_reg = 5'd5;
        bus.i_id_rs1 = 5'd5; bus.i_id_rs_used = 2'b01;
        issue();
        idle_inputs(); issue();
        bus.i_ex_is_load = 1'b1; bus.i_ex_dest_reg = 5'd0;
        bus.i_id_rs1 = 5'd0; bus.i_id_rs_used = 2'b01;
        issue();
        idle_inputs(); issue();

        // 3: branch together with load-use
        cur_tid = 3;
        bus.i_ex_is_load = 1'b1; bus.i_ex_dest_reg = 5'd7;
        bus.i_id_rs2 = 5'd7; bus.i_id_rs_used = 2'b10; bus.i_branch = 1'b1;
        issue();
        idle_inputs(); issue();

        // 4: three WAIT cycles then OK
        cur_tid = 4;
        bus.i_mem_req = 1'b1; bus.i_mem_res_code = MEM_CODE_WAIT;
        repeat (3) issue();
        bus.i_mem_res_code = MEM_CODE_OK;
        issue();
        idle_inputs(); issue();

        // 5: watchdog timeout into FAULT, then soft reset back to RUN
        cur_tid = 5;
        bus.i_mem_req = 1'b1; bus.i_mem_res_code = MEM_CODE_WAIT;
        repeat (MT + 1) issue();
        idle_inputs();
        repeat (2) issue();
        i_resetn = 1'b0; issue();
        i_resetn = 1'b1;
        repeat (3) issue();

        // 6: soft reset during the second WAIT cycle
        cur_tid = 6;
        bus.i_mem_req = 1'b1; bus.i_mem_res_code = MEM_CODE_WAIT;
        issue();
        i_resetn = 1'b0; issue();
        i_resetn = 1'b1; idle_inputs();
        repeat (3) issue();

        // 7: randomized traffic
        cur_tid = 7;
        for (int c = 0; c < 600; c++) begin
            aresetn  = ($urandom_range(0, 149) != 0);
            i_resetn = ($urandom_range(0, 59) != 0);
            bus.i_id_rs1      = 5'($urandom_range(0, 3));
            bus.i_id_rs2      = 5'($urandom_range(0, 3));
            bus.i_id_rs_used  = 2'($urandom_range(0, 3));
            bus.i_ex_dest_reg = 5'($urandom_range(0, 3));
            bus.i_ex_is_load  = 1'($urandom_range(0, 1));
            bus.i_branch      = ($urandom_range(0, 4) == 0);
            if (m_st == PC_MEM_WAIT) begin
                bus.i_mem_req = 1'b1;
                r = $urandom_range(0, 19);
                bus.i_mem_res_code = (r < 13) ? MEM_CODE_WAIT :
                                     (r < 15) ? 2'd3 :
                                     (r < 19) ? MEM_CODE_OK : MEM_CODE_ERR;
            end else begin
                bus.i_mem_req = ($urandom_range(0, 3) == 0);
                r = $urandom_range(0, 9);
                bus.i_mem_res_code = (r < 6) ? MEM_CODE_OK :
                                     (r < 8) ? MEM_CODE_WAIT :
                                     (r < 9) ? 2'd3 : MEM_CODE_ERR;
            end
            issue();
        end
        aresetn  = 1'b1;
        i_resetn = 1'b1;
        idle_inputs();

        repeat (2) @(negedge clk);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard drain: got %0d pending, want 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
